logic32_seq: RTL

- Multi-cycle bitwise logic unit for the Full ALU. It is the responder end of a valid/ready operand request interface.
- Accepts two 32-bit operands plus an opcode, then computes the result one SLICE-bit chunk per cycle.
- Returns the result and a zero flag on a valid/ready response channel.
- Lets the ALU controller share one narrow logic slice in the area-reduced configuration. The datapath is the same one the combinational and/or/xor arrays provide.

---
 rtl/alu_logic_pkg.sv | 15 +
 rtl/logic_slice.sv | 24 ++
 rtl/logic32_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_logic_pkg.sv
// Shared opcode and state encodings for the sequential bitwise logic unit.
package alu_logic_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_ANDN = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-wide bitwise op unit, reused every cycle by logic32_seq.
module logic_slice
   import alu_logic_pkg::*;
#(
   parameter int unsigned SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic [1:0]       op,
   output logic [SLICE-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_ANDN: y = a & ~b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic32_seq.sv
// Multi-cycle bitwise logic unit: one SLICE-bit chunk per cycle through a shared slice,
// valid/ready request in, valid/ready response out.
module logic32_seq
   import alu_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("logic32_seq: WIDTH must be a multiple of SLICE");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;

   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE-1:0] slice_y;
   logic [WIDTH-1:0] res_next;

   assign a_sl = a_q[cnt_q*SLICE +: SLICE];
   assign b_sl = b_q[cnt_q*SLICE +: SLICE];

   logic_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a  (a_sl),
      .b  (b_sl),
      .op (op_q),
      .y  (slice_y)
   );

   // Full result with the current slice merged in; the zero flag on the last slice needs it.
   always_comb begin
      res_next = rsp_result;
      res_next[cnt_q*SLICE +: SLICE] = slice_y;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid && req_ready) begin
                  a_q        <= req_a;
                  b_q        <= req_b;
                  op_q       <= req_op;
                  cnt_q      <= '0;
                  rsp_result <= '0;
                  rsp_zero   <= 1'b0;
                  req_ready  <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               rsp_result <= res_next;
               cnt_q      <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  rsp_valid <= 1'b1;
                  rsp_zero  <= (res_next == '0);
                  state_q   <= DONE;
               end
            end
            DONE: begin
               // No accept on the handshake edge: req_ready only returns once back in IDLE.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
